// File: rtl/dram_sequencer_if.sv
// Request/response port between the chip-internal DRAM wrapper and dram_sequencer.
// The master drives requests; the slave (the sequencer) returns read data and completions.
interface dram_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [20:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_last;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_last
  );
endinterface

// File: rtl/dram_sequencer.sv
// Open-row DRAM command sequencer: single-word writes and 1-4 beat incrementing reads,
// with programmable PRECHARGE->ACTIVATE, ACTIVATE->column and WRITE hold spacing.
module dram_sequencer #(
  parameter int T_RP  = 5,
  parameter int T_RCD = 5,
  parameter int T_WR  = 5
) (
  input  logic            dram_clk,
  input  logic            dram_rst,
  dram_sequencer_if.slave req,
  output logic            DRAM_CSn,
  output logic            DRAM_RASn,
  output logic            DRAM_CASn,
  output logic [3:0]      DRAM_WEn,
  output logic [10:0]     DRAM_A,
  output logic [31:0]     DRAM_D,
  input  logic [31:0]     DRAM_Q,
  input  logic            DRAM_valid
);
  localparam int T_MAX  = (T_RP > T_RCD) ? ((T_RP > T_WR) ? T_RP : T_WR)
                                         : ((T_RCD > T_WR) ? T_RCD : T_WR);
  localparam int WAIT_W = $clog2(T_MAX) + 1;
  localparam logic [WAIT_W-1:0] RP_LOAD  = WAIT_W'(T_RP - 1);
  localparam logic [WAIT_W-1:0] RCD_LOAD = WAIT_W'(T_RCD - 1);
  localparam logic [WAIT_W-1:0] WR_LOAD  = WAIT_W'(T_WR - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    ACT     = 3'd2,
    RD      = 3'd3,
    RD_WAIT = 3'd4,
    WR      = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t            state_r, state_next_s;
  logic [WAIT_W-1:0] wait_r, wait_next_s;
  logic [9:0]        col_r, col_next_s;
  logic [10:0]       row_r, row_next_s, open_row_r;
  logic              row_open_r;
  logic [1:0]        beats_r, beats_next_s;
  logic              write_r, write_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [3:0]        wstrb_r, wstrb_s;

  logic              cs_n_s, ras_n_s, cas_n_s;
  logic [3:0]        we_n_s;
  logic [10:0]       a_s;
  logic [31:0]       d_s;

  logic              cs_n_r, ras_n_r, cas_n_r;
  logic [3:0]        we_n_r;
  logic [10:0]       a_r;
  logic [31:0]       d_r;
  logic              req_ready_r, rsp_valid_r, rsp_last_r;
  logic [31:0]       rsp_rdata_r;

  // Next state, wait counter, column/beat bookkeeping and request capture
  always_comb begin
    state_next_s = state_r;
    wait_next_s  = wait_r;
    col_next_s   = col_r;
    row_next_s   = row_r;
    beats_next_s = beats_r;
    write_s      = write_r;
    wdata_s      = wdata_r;
    wstrb_s      = wstrb_r;
    case (state_r)
      IDLE: begin
        if (req.req_valid && req_ready_r) begin
          write_s      = req.req_write;
          wdata_s      = req.req_wdata;
          wstrb_s      = req.req_wstrb;
          row_next_s   = req.req_addr[20:10];
          col_next_s   = req.req_addr[9:0];
          beats_next_s = req.req_write ? 2'd0 : req.req_len;
          if (row_open_r && (req.req_addr[20:10] == open_row_r)) begin
            state_next_s = req.req_write ? WR : RD;
            wait_next_s  = req.req_write ? WR_LOAD : WAIT_ZERO;
          end else if (!row_open_r) begin
            state_next_s = ACT;
            wait_next_s  = RCD_LOAD;
          end else begin
            state_next_s = PRE;
            wait_next_s  = RP_LOAD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      PRE: begin
        if (wait_r == WAIT_ZERO) begin
          state_next_s = ACT;
          wait_next_s  = RCD_LOAD;
        end else begin
          wait_next_s  = wait_r - WAIT_ONE;
        end
      end
      ACT: begin
        if (wait_r == WAIT_ZERO) begin
          state_next_s = write_r ? WR : RD;
          wait_next_s  = write_r ? WR_LOAD : WAIT_ZERO;
        end else begin
          wait_next_s  = wait_r - WAIT_ONE;
        end
      end
      RD: begin
        state_next_s = RD_WAIT;
      end
      RD_WAIT: begin
        if (DRAM_valid) begin
          state_next_s = RESP;
        end else begin
          state_next_s = RD_WAIT;
        end
      end
      WR: begin
        if (wait_r == WAIT_ZERO) begin
          state_next_s = RESP;
        end else begin
          wait_next_s  = wait_r - WAIT_ONE;
        end
      end
      RESP: begin
        // Column increments wrap inside the open row; no new ACTIVATE is needed
        if (beats_r != 2'd0) begin
          state_next_s = RD;
          beats_next_s = beats_r - 2'd1;
          col_next_s   = col_r + 10'd1;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Pin command for the state being entered; registered on the next edge
  always_comb begin
    cs_n_s  = 1'b1;
    ras_n_s = 1'b1;
    cas_n_s = 1'b1;
    we_n_s  = 4'hF;
    a_s     = 11'h000;
    d_s     = 32'h0000_0000;
    case (state_next_s)
      PRE: begin
        if (state_r != PRE) begin
          cs_n_s  = 1'b0;
          ras_n_s = 1'b0;
          we_n_s  = 4'h0;
        end else begin
          cs_n_s  = 1'b1;
        end
      end
      ACT: begin
        if (state_r != ACT) begin
          cs_n_s  = 1'b0;
          ras_n_s = 1'b0;
          a_s     = row_next_s;
        end else begin
          cs_n_s  = 1'b1;
        end
      end
      RD: begin
        cs_n_s  = 1'b0;
        cas_n_s = 1'b0;
        a_s     = {1'b0, col_next_s};
      end
      WR: begin
        cs_n_s  = 1'b0;
        cas_n_s = 1'b0;
        we_n_s  = ~wstrb_s;
        a_s     = {1'b0, col_next_s};
        d_s     = wdata_s;
      end
      default: begin
        cs_n_s  = 1'b1;
      end
    endcase
  end

  // Sequencer state, captured request and open-row tracking
  always_ff @(posedge dram_clk or posedge dram_rst) begin
    if (dram_rst) begin
      state_r    <= IDLE;
      wait_r     <= WAIT_ZERO;
      col_r      <= 10'h000;
      row_r      <= 11'h000;
      beats_r    <= 2'd0;
      write_r    <= 1'b0;
      wdata_r    <= 32'h0000_0000;
      wstrb_r    <= 4'h0;
      row_open_r <= 1'b0;
      open_row_r <= 11'h000;
    end else begin
      state_r <= state_next_s;
      wait_r  <= wait_next_s;
      col_r   <= col_next_s;
      row_r   <= row_next_s;
      beats_r <= beats_next_s;
      write_r <= write_s;
      wdata_r <= wdata_s;
      wstrb_r <= wstrb_s;
      if ((state_r == PRE) && (state_next_s != PRE)) begin
        row_open_r <= 1'b0;
      end else if ((state_r == ACT) && (state_next_s != ACT)) begin
        row_open_r <= 1'b1;
        open_row_r <= row_r;
      end
    end
  end

  // Registered DRAM pins and response port
  always_ff @(posedge dram_clk or posedge dram_rst) begin
    if (dram_rst) begin
      cs_n_r      <= 1'b1;
      ras_n_r     <= 1'b1;
      cas_n_r     <= 1'b1;
      we_n_r      <= 4'hF;
      a_r         <= 11'h000;
      d_r         <= 32'h0000_0000;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      cs_n_r      <= cs_n_s;
      ras_n_r     <= ras_n_s;
      cas_n_r     <= cas_n_s;
      we_n_r      <= we_n_s;
      a_r         <= a_s;
      d_r         <= d_s;
      req_ready_r <= (state_next_s == IDLE);
      rsp_valid_r <= (state_next_s == RESP);
      rsp_last_r  <= (state_next_s == RESP) && (beats_r == 2'd0);
      rsp_rdata_r <= ((state_r == RD_WAIT) && (state_next_s == RESP)) ? DRAM_Q : 32'h0000_0000;
    end
  end

  assign DRAM_CSn      = cs_n_r;
  assign DRAM_RASn     = ras_n_r;
  assign DRAM_CASn     = cas_n_r;
  assign DRAM_WEn      = we_n_r;
  assign DRAM_A        = a_r;
  assign DRAM_D        = d_r;
  assign req.req_ready = req_ready_r;
  assign req.rsp_valid = rsp_valid_r;
  assign req.rsp_last  = rsp_last_r;
  assign req.rsp_rdata = rsp_rdata_r;
endmodule

// File: tb/tb_dram_sequencer.sv
// Directed bench for dram_sequencer: a pin monitor logs every non-NOP command and response
// with its cycle number; a simple DRAM model answers each READ after a programmable latency.
module tb_dram_sequencer;
  logic        dram_clk = 1'b0;
  logic        dram_rst;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q;
  logic        DRAM_valid;

  dram_sequencer_if bus();

  dram_sequencer #(.T_RP(5), .T_RCD(5), .T_WR(5)) dut (
    .dram_clk   (dram_clk),
    .dram_rst   (dram_rst),
    .req        (bus),
    .DRAM_CSn   (DRAM_CSn),
    .DRAM_RASn  (DRAM_RASn),
    .DRAM_CASn  (DRAM_CASn),
    .DRAM_WEn   (DRAM_WEn),
    .DRAM_A     (DRAM_A),
    .DRAM_D     (DRAM_D),
    .DRAM_Q     (DRAM_Q),
    .DRAM_valid (DRAM_valid)
  );

  always #5 dram_clk = ~dram_clk;

  typedef struct { int cyc; int kind; logic [10:0] a; logic [3:0] wen; logic [31:0] d; } cmd_t;
  typedef struct { int cyc; logic [31:0] data; logic last; } rsp_t;

  cmd_t        cmd_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rdq[$];
  int          cyc = 0;
  int          dram_lat = 1;
  int          rd_cd = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // kinds: 0 NOP, 1 PRECHARGE, 2 ACTIVATE, 3 READ, 4 WRITE, 5 illegal
  function automatic int pin_kind();
    if ({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D} === {3'b111, 4'hF, 11'h000, 32'h0}) return 0;
    if ({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn} === {3'b001, 4'h0}) return 1;
    if ({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn} === {3'b001, 4'hF}) return 2;
    if ({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn} === {3'b010, 4'hF}) return 3;
    if ({DRAM_CSn, DRAM_RASn, DRAM_CASn} === 3'b010) return 4;
    return 5;
  endfunction

  function automatic int ck(int i); return (i < cmd_q.size()) ? cmd_q[i].kind : -1; endfunction
  function automatic int cc(int i); return (i < cmd_q.size()) ? cmd_q[i].cyc : -1; endfunction
  function automatic logic [10:0] ca(int i); return (i < cmd_q.size()) ? cmd_q[i].a : 11'hxxx; endfunction
  function automatic int rc(int i); return (i < rsp_q.size()) ? rsp_q[i].cyc : -1; endfunction
  function automatic logic [31:0] rd(int i); return (i < rsp_q.size()) ? rsp_q[i].data : 32'hxxxx_xxxx; endfunction
  function automatic logic rl(int i); return (i < rsp_q.size()) ? rsp_q[i].last : 1'bx; endfunction
  function automatic bit done(); return (rsp_q.size() > 0) && rsp_q[rsp_q.size()-1].last; endfunction

  initial forever begin
    @(posedge dram_clk);
    cyc = cyc + 1;
  end

  // Pin monitor and DRAM read-data model, both sampled on the falling edge
  initial begin
    int k;
    DRAM_valid = 1'b0;
    DRAM_Q     = 32'h0;
    forever begin
      @(negedge dram_clk);
      DRAM_valid = 1'b0;
      DRAM_Q     = 32'hBAD0_BAD0;
      if (dram_rst) rd_cd = 0;
      else if (rd_cd > 0) begin
        rd_cd = rd_cd - 1;
        if (rd_cd == 0) begin
          DRAM_valid = 1'b1;
          DRAM_Q     = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
        end
      end
      k = pin_kind();
      if (k != 0) cmd_q.push_back('{cyc, k, DRAM_A, DRAM_WEn, DRAM_D});
      if (k == 3 && !dram_rst) rd_cd = dram_lat;
      if (bus.rsp_valid) rsp_q.push_back('{cyc, bus.rsp_rdata, bus.rsp_last});
    end
  end

  task automatic step();
    @(negedge dram_clk);
    #1;
  endtask

  task automatic clear_logs();
    cmd_q.delete();
    rsp_q.delete();
    rdq.delete();
  endtask

  task automatic issue(input logic wr, input logic [20:0] addr, input logic [1:0] len,
                       input logic [31:0] wd, input logic [3:0] ws, input bit keep, output int acc);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        acc = cyc;
        break;
      end
      step();
    end
    n_checks++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1 within 50 cycles", bus.req_ready);
    end
    @(posedge dram_clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      if (done()) break;
      step();
    end
    n_checks++;
    if (!done()) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d responses seen, required one with rsp_last", name, rsp_q.size());
    end
  endtask

  task automatic test_reset();
    dram_rst = 1'b1;
    step(); step(); step();
    n_checks++;
    if ({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D} !== {3'b111, 4'hF, 11'h000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_pins: got %b %b %b %h %h %h, required NOP", DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_last, bus.rsp_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_rsp: got valid %b last %b rdata %h, required 0 0 0", bus.rsp_valid, bus.rsp_last, bus.rsp_rdata);
    end
    dram_rst = 1'b0;
    step();
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_closed_row_read();
    int acc;
    clear_logs();
    dram_lat = 5;
    rdq.push_back(32'hDEAD_BEEF);
    issue(1'b0, 21'h1_0005, 2'd0, 32'h0, 4'h0, 1'b0, acc);
    wait_done(60, "closed");
    n_checks++;
    if (cmd_q.size() !== 2) begin
      n_fail++;
      $display("FAIL closed_cmd_count: got %0d required 2", cmd_q.size());
    end
    n_checks++;
    if (ck(0) !== 2 || cc(0) - acc !== 1 || ca(0) !== 11'h040) begin
      n_fail++;
      $display("FAIL closed_act: got kind %0d cycle %0d A %h, required kind 2 cycle 1 A 040", ck(0), cc(0) - acc, ca(0));
    end
    n_checks++;
    if (ck(1) !== 3 || cc(1) - acc !== 6 || ca(1) !== 11'h005) begin
      n_fail++;
      $display("FAIL closed_read: got kind %0d cycle %0d A %h, required kind 3 cycle 6 A 005", ck(1), cc(1) - acc, ca(1));
    end
    n_checks++;
    if (rsp_q.size() !== 1 || rc(0) - acc !== 12 || rd(0) !== 32'hDEAD_BEEF || rl(0) !== 1'b1) begin
      n_fail++;
      $display("FAIL closed_rsp: got n %0d cycle %0d data %h last %b, required 1 12 deadbeef 1", rsp_q.size(), rc(0) - acc, rd(0), rl(0));
    end
    step();
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL closed_ready_after_last: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_row_hit_burst();
    int acc;
    logic [10:0] exp_a [4] = '{11'h3FE, 11'h3FF, 11'h000, 11'h001};
    logic [31:0] exp_d [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    clear_logs();
    dram_lat = 2;
    for (int i = 0; i < 4; i++) rdq.push_back(exp_d[i]);
    issue(1'b0, 21'h1_03FE, 2'd3, 32'h0, 4'h0, 1'b0, acc);
    wait_done(100, "burst");
    n_checks++;
    if (cmd_q.size() !== 4 || rsp_q.size() !== 4) begin
      n_fail++;
      $display("FAIL burst_counts: got %0d cmds %0d rsps, required 4 and 4", cmd_q.size(), rsp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ck(i) !== 3 || cc(i) - acc !== 1 + 4 * i || ca(i) !== exp_a[i]) begin
        n_fail++;
        $display("FAIL burst_read%0d: got kind %0d cycle %0d A %h, required kind 3 cycle %0d A %h", i, ck(i), cc(i) - acc, ca(i), 1 + 4 * i, exp_a[i]);
      end
      n_checks++;
      if (rc(i) - acc !== 4 + 4 * i || rd(i) !== exp_d[i] || rl(i) !== (i == 3)) begin
        n_fail++;
        $display("FAIL burst_rsp%0d: got cycle %0d data %h last %b, required %0d %h %b", i, rc(i) - acc, rd(i), rl(i), 4 + 4 * i, exp_d[i], (i == 3));
      end
    end
  endtask

  task automatic test_row_miss_write();
    int acc;
    clear_logs();
    issue(1'b1, 21'h4_8C10, 2'd0, 32'h1122_3344, 4'b0101, 1'b0, acc);
    wait_done(60, "write");
    n_checks++;
    if (cmd_q.size() !== 7) begin
      n_fail++;
      $display("FAIL write_cmd_count: got %0d required 7", cmd_q.size());
    end
    n_checks++;
    if (ck(0) !== 1 || cc(0) - acc !== 1) begin
      n_fail++;
      $display("FAIL write_pre: got kind %0d cycle %0d, required kind 1 cycle 1", ck(0), cc(0) - acc);
    end
    n_checks++;
    if (ck(1) !== 2 || cc(1) - acc !== 6 || ca(1) !== 11'h123) begin
      n_fail++;
      $display("FAIL write_act: got kind %0d cycle %0d A %h, required kind 2 cycle 6 A 123", ck(1), cc(1) - acc, ca(1));
    end
    for (int i = 2; i < 7; i++) begin
      n_checks++;
      if (ck(i) !== 4 || cc(i) - acc !== 9 + i || ca(i) !== 11'h010 || i >= cmd_q.size()
          || cmd_q[i].wen !== 4'b1010 || cmd_q[i].d !== 32'h1122_3344) begin
        n_fail++;
        $display("FAIL write_beat%0d: got kind %0d cycle %0d A %h, required kind 4 cycle %0d A 010 WEn 1010 D 11223344", i, ck(i), cc(i) - acc, ca(i), 9 + i);
      end
    end
    n_checks++;
    if (rsp_q.size() !== 1 || rc(0) - acc !== 16 || rd(0) !== 32'h0 || rl(0) !== 1'b1) begin
      n_fail++;
      $display("FAIL write_rsp: got n %0d cycle %0d data %h last %b, required 1 16 0 1", rsp_q.size(), rc(0) - acc, rd(0), rl(0));
    end
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2 = -1;
    clear_logs();
    dram_lat = 1;
    rdq.push_back(32'hAAAA_0020);
    rdq.push_back(32'hBBBB_0021);
    issue(1'b0, 21'h4_8C20, 2'd0, 32'h0, 4'h0, 1'b1, acc1);
    bus.req_addr = 21'h4_8C21;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.req_ready) begin
        acc2 = cyc;
        break;
      end
    end
    @(posedge dram_clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 30 && rsp_q.size() < 2; i++) step();
    n_checks++;
    if (acc2 - acc1 !== 4) begin
      n_fail++;
      $display("FAIL b2b_second_accept: got cycle %0d required 4", acc2 - acc1);
    end
    n_checks++;
    if (cmd_q.size() !== 2 || ck(0) !== 3 || ck(1) !== 3 || cc(1) - acc1 !== 5 || ca(1) !== 11'h021) begin
      n_fail++;
      $display("FAIL b2b_cmds: got n %0d kinds %0d %0d second cycle %0d A %h, required 2 reads, second at 5 A 021", cmd_q.size(), ck(0), ck(1), cc(1) - acc1, ca(1));
    end
    n_checks++;
    if (rsp_q.size() !== 2 || rc(0) - acc1 !== 3 || rl(0) !== 1'b1 || rc(1) - acc1 !== 7 || rd(1) !== 32'hBBBB_0021) begin
      n_fail++;
      $display("FAIL b2b_rsps: got n %0d cycles %0d %0d last0 %b data1 %h, required 2 3 7 1 bbbb0021", rsp_q.size(), rc(0) - acc1, rc(1) - acc1, rl(0), rd(1));
    end
  endtask

  task automatic test_stalled_dram();
    int acc;
    clear_logs();
    dram_lat = 101;
    rdq.push_back(32'hCAFE_F00D);
    issue(1'b0, 21'h4_8C30, 2'd0, 32'h0, 4'h0, 1'b0, acc);
    for (int i = 0; i < 50; i++) step();
    n_checks++;
    if (pin_kind() !== 0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle_pins: got kind %0d ready %b rsp_valid %b, required 0 0 0", pin_kind(), bus.req_ready, bus.rsp_valid);
    end
    wait_done(200, "stall");
    n_checks++;
    if (cmd_q.size() !== 1 || cc(0) - acc !== 1 || rc(0) - acc !== 103 || rd(0) !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL stall_complete: got n %0d read cycle %0d rsp cycle %0d data %h, required 1 1 103 cafef00d", cmd_q.size(), cc(0) - acc, rc(0) - acc, rd(0));
    end
  endtask

  task automatic test_reset_mid_act();
    int acc;
    clear_logs();
    issue(1'b0, 21'h00_0005, 2'd0, 32'h0, 4'h0, 1'b0, acc);
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (pin_kind() !== 2) begin
      n_fail++;
      $display("FAIL midact_act_pins: got kind %0d required 2 at cycle 6", pin_kind());
    end
    #2;
    dram_rst = 1'b1;
    #1;
    n_checks++;
    if (pin_kind() !== 0 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midact_reset_pins: got kind %0d rsp_valid %b, required NOP 0", pin_kind(), bus.rsp_valid);
    end
    step(); step();
    dram_rst = 1'b0;
    step();
    clear_logs();
    dram_lat = 3;
    rdq.push_back(32'h0BAD_CAFE);
    issue(1'b0, 21'h00_0005, 2'd0, 32'h0, 4'h0, 1'b0, acc);
    wait_done(60, "midact");
    n_checks++;
    if (cmd_q.size() !== 2 || ck(0) !== 2 || cc(0) - acc !== 1 || ca(0) !== 11'h000
        || ck(1) !== 3 || cc(1) - acc !== 6 || ca(1) !== 11'h005) begin
      n_fail++;
      $display("FAIL midact_reread: got n %0d kinds %0d %0d cycles %0d %0d, required ACT@1 A 000 READ@6 A 005", cmd_q.size(), ck(0), ck(1), cc(0) - acc, cc(1) - acc);
    end
    n_checks++;
    if (rsp_q.size() !== 1 || rc(0) - acc !== 10 || rd(0) !== 32'h0BAD_CAFE) begin
      n_fail++;
      $display("FAIL midact_rsp: got n %0d cycle %0d data %h, required 1 10 0badcafe", rsp_q.size(), rc(0) - acc, rd(0));
    end
  endtask

  task automatic test_reset_row_open();
    int acc;
    step();
    dram_rst = 1'b1;
    step();
    dram_rst = 1'b0;
    step();
    clear_logs();
    dram_lat = 1;
    rdq.push_back(32'h6666_0006);
    issue(1'b0, 21'h00_0006, 2'd0, 32'h0, 4'h0, 1'b0, acc);
    wait_done(60, "rowopen");
    n_checks++;
    if (ck(0) !== 2 || cc(0) - acc !== 1 || ck(1) !== 3 || cc(1) - acc !== 6) begin
      n_fail++;
      $display("FAIL rowopen_after_reset: got kinds %0d %0d cycles %0d %0d, required ACT@1 READ@6", ck(0), ck(1), cc(0) - acc, cc(1) - acc);
    end
  endtask

  initial begin
    dram_rst      = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 21'h0;
    bus.req_len   = 2'd0;
    bus.req_wdata = 32'h0;
    bus.req_wstrb = 4'h0;
    test_reset();
    test_closed_row_read();
    test_row_hit_burst();
    test_row_miss_write();
    test_back_to_back();
    test_stalled_dram();
    test_reset_mid_act();
    test_reset_row_open();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
